// File: rtl/branch_resolve_ctrl_if.sv
// Bus between ID-stage decode / pipeline hazard sources and the branch resolution controller.
interface branch_resolve_ctrl_if #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH      = 16
);
  localparam int unsigned COND_TYPE_WIDTH = 2;

  logic                       id_valid;
  logic [COND_TYPE_WIDTH-1:0] id_cond_type;
  logic [REG_ADDR_WIDTH-1:0]  id_rs;
  logic [REG_ADDR_WIDTH-1:0]  id_rt;
  logic [DATA_WIDTH-1:0]      id_rs_data;
  logic [DATA_WIDTH-1:0]      id_rt_data;
  logic [DATA_WIDTH-1:0]      id_target;
  logic                       ex_reg_write;
  logic                       ex_mem_read;
  logic [REG_ADDR_WIDTH-1:0]  ex_dst;
  logic                       mem_reg_write;
  logic                       mem_mem_read;
  logic [REG_ADDR_WIDTH-1:0]  mem_dst;
  logic [DATA_WIDTH-1:0]      mem_alu_result;
  logic                       wb_reg_write;
  logic [REG_ADDR_WIDTH-1:0]  wb_dst;
  logic [DATA_WIDTH-1:0]      wb_data;
  logic                       cnt_clear;

  logic                       stall_if_id;
  logic                       flush_if_id;
  logic                       pc_redirect;
  logic [DATA_WIDTH-1:0]      pc_target;
  logic [CNT_WIDTH-1:0]       cnt_branches;
  logic [CNT_WIDTH-1:0]       cnt_taken;
  logic [CNT_WIDTH-1:0]       cnt_stalls;
  logic                       stall_timeout;

  modport master (
    output id_valid, id_cond_type, id_rs, id_rt, id_rs_data, id_rt_data, id_target,
           ex_reg_write, ex_mem_read, ex_dst, mem_reg_write, mem_mem_read, mem_dst,
           mem_alu_result, wb_reg_write, wb_dst, wb_data, cnt_clear,
    input  stall_if_id, flush_if_id, pc_redirect, pc_target,
           cnt_branches, cnt_taken, cnt_stalls, stall_timeout
  );

  modport slave (
    input  id_valid, id_cond_type, id_rs, id_rt, id_rs_data, id_rt_data, id_target,
           ex_reg_write, ex_mem_read, ex_dst, mem_reg_write, mem_mem_read, mem_dst,
           mem_alu_result, wb_reg_write, wb_dst, wb_data, cnt_clear,
    output stall_if_id, flush_if_id, pc_redirect, pc_target,
           cnt_branches, cnt_taken, cnt_stalls, stall_timeout
  );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// ID-stage BEQ/BNQ resolution: operand forwarding, load-use/EX stall, PC redirect,
// saturating performance counters and a sticky stall watchdog.
module branch_resolve_ctrl #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH      = 16,
  parameter int unsigned MAX_STALL      = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  branch_resolve_ctrl_if.slave br_if
);

  localparam int unsigned COND_TYPE_WIDTH = 2;
  localparam logic [COND_TYPE_WIDTH-1:0] COND_BEQ = 2'b01;
  localparam logic [COND_TYPE_WIDTH-1:0] COND_BNQ = 2'b10;
  localparam int unsigned RUN_WIDTH = $clog2(MAX_STALL + 1);
  localparam logic [RUN_WIDTH-1:0] RUN_MAX = RUN_WIDTH'(MAX_STALL);

  localparam logic [0:0] ST_READY   = 1'b0;
  localparam logic [0:0] ST_STALLED = 1'b1;

  logic [1:0][REG_ADDR_WIDTH-1:0] src_idx;
  logic [1:0][DATA_WIDTH-1:0]     src_rf;
  logic [1:0][DATA_WIDTH-1:0]     opnd;
  logic [1:0]                     haz;

  logic is_branch_c;
  logic hazard_c;
  logic stall_c;
  logic resolve_c;
  logic taken_c;

  logic [0:0]           state_q, state_d;
  logic [RUN_WIDTH-1:0] run_q, run_d;
  logic                 timeout_q, timeout_d;
  logic [CNT_WIDTH-1:0] cnt_branches_q, cnt_branches_d;
  logic [CNT_WIDTH-1:0] cnt_taken_q, cnt_taken_d;
  logic [CNT_WIDTH-1:0] cnt_stalls_q, cnt_stalls_d;

  assign src_idx = {br_if.id_rt, br_if.id_rs};
  assign src_rf  = {br_if.id_rt_data, br_if.id_rs_data};

  // Per-operand hazard detection and forwarding, youngest producer first.
  always_comb begin
    haz  = '0;
    opnd = src_rf;
    for (int i = 0; i < 2; i++) begin
      if (src_idx[i] != '0) begin
        if (br_if.ex_reg_write && (src_idx[i] == br_if.ex_dst)) begin
          haz[i] = 1'b1;
        end else if (br_if.mem_reg_write && (src_idx[i] == br_if.mem_dst)) begin
          if (br_if.mem_mem_read) haz[i] = 1'b1;
          else                    opnd[i] = br_if.mem_alu_result;
        end else if (br_if.wb_reg_write && (src_idx[i] == br_if.wb_dst)) begin
          opnd[i] = br_if.wb_data;
        end
      end
    end
  end

  assign is_branch_c = br_if.id_valid &&
                       ((br_if.id_cond_type == COND_BEQ) || (br_if.id_cond_type == COND_BNQ));
  assign hazard_c    = |haz;
  assign stall_c     = is_branch_c && hazard_c && rst_n;
  assign resolve_c   = is_branch_c && !hazard_c;
  assign taken_c     = resolve_c &&
                       ((br_if.id_cond_type == COND_BEQ) ? (opnd[0] == opnd[1])
                                                         : (opnd[0] != opnd[1]));

  assign br_if.stall_if_id   = stall_c;
  assign br_if.flush_if_id   = taken_c;
  assign br_if.pc_redirect   = taken_c;
  assign br_if.pc_target     = br_if.id_target;
  assign br_if.cnt_branches  = cnt_branches_q;
  assign br_if.cnt_taken     = cnt_taken_q;
  assign br_if.cnt_stalls    = cnt_stalls_q;
  assign br_if.stall_timeout = timeout_q;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                   input logic en);
    return (en && (v != '1)) ? v + CNT_WIDTH'(1) : v;
  endfunction

  // Next-state: stall FSM, run length, watchdog and counters.
  always_comb begin
    state_d        = state_q;
    run_d          = run_q;
    timeout_d      = timeout_q;
    cnt_branches_d = cnt_branches_q;
    cnt_taken_d    = cnt_taken_q;
    cnt_stalls_d   = cnt_stalls_q;

    case (state_q)
      ST_READY:   if (stall_c) state_d = ST_STALLED;
      ST_STALLED: if (!stall_c || !br_if.id_valid) state_d = ST_READY;
      default:    state_d = ST_READY;
    endcase

    if (state_d == ST_STALLED) run_d = (run_q == RUN_MAX) ? run_q : run_q + RUN_WIDTH'(1);
    else                       run_d = '0;

    if (br_if.cnt_clear) begin
      timeout_d      = 1'b0;
      cnt_branches_d = '0;
      cnt_taken_d    = '0;
      cnt_stalls_d   = '0;
    end else begin
      if (stall_c && (run_q == RUN_MAX)) timeout_d = 1'b1;
      cnt_branches_d = sat_inc(cnt_branches_q, resolve_c);
      cnt_taken_d    = sat_inc(cnt_taken_q, taken_c);
      cnt_stalls_d   = sat_inc(cnt_stalls_q, stall_c);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_READY;
      run_q          <= '0;
      timeout_q      <= 1'b0;
      cnt_branches_q <= '0;
      cnt_taken_q    <= '0;
      cnt_stalls_q   <= '0;
    end else begin
      state_q        <= state_d;
      run_q          <= run_d;
      timeout_q      <= timeout_d;
      cnt_branches_q <= cnt_branches_d;
      cnt_taken_q    <= cnt_taken_d;
      cnt_stalls_q   <= cnt_stalls_d;
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Bench for branch_resolve_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_branch_resolve_ctrl;

  localparam int unsigned DW        = 32;
  localparam int unsigned RW        = 5;
  localparam int unsigned CW        = 16;
  localparam int          MAX_STALL = 3;
  localparam int          CNT_MAX   = 65535;
  localparam logic [1:0]  BEQ       = 2'b01;
  localparam logic [1:0]  BNQ       = 2'b10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  branch_resolve_ctrl_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW), .CNT_WIDTH(CW)) br ();

  branch_resolve_ctrl #(
    .DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW), .CNT_WIDTH(CW), .MAX_STALL(MAX_STALL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .br_if (br.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int m_branches = 0, m_taken = 0, m_stalls = 0, m_run = 0;
  bit m_timeout = 1'b0;
  bit m_stall, m_resolve, m_tk;
  bit obs_stall, obs_redirect;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v < CNT_MAX) ? v + 1 : v;
  endfunction

  // Operand value as the ISA sees it, or a hazard if the producer has not delivered it yet.
  function automatic void operand(input logic [RW-1:0] idx, input logic [DW-1:0] rf,
                                  output bit hz, output logic [DW-1:0] val);
    hz  = 1'b0;
    val = rf;
    if (idx == 0) return;
    if (br.ex_reg_write && idx == br.ex_dst) begin hz = 1'b1; return; end
    if (br.mem_reg_write && idx == br.mem_dst) begin
      if (br.mem_mem_read) hz = 1'b1; else val = br.mem_alu_result;
      return;
    end
    if (br.wb_reg_write && idx == br.wb_dst) val = br.wb_data;
  endfunction

  task automatic eval_and_check(input string ph);
    bit ha, hb, active;
    logic [DW-1:0] va, vb;
    active = br.id_valid && (br.id_cond_type == BEQ || br.id_cond_type == BNQ);
    operand(br.id_rs, br.id_rs_data, ha, va);
    operand(br.id_rt, br.id_rt_data, hb, vb);
    m_stall   = active && (ha || hb) && (rst_n === 1'b1);
    m_resolve = active && !(ha || hb);
    m_tk      = m_resolve && ((br.id_cond_type == BEQ) ? (va == vb) : (va != vb));
    obs_stall    = br.stall_if_id;
    obs_redirect = br.pc_redirect;
    check({ph, "_stall"},    64'(br.stall_if_id),   64'(m_stall));
    check({ph, "_redirect"}, 64'(br.pc_redirect),   64'(m_tk));
    check({ph, "_flush"},    64'(br.flush_if_id),   64'(m_tk));
    check({ph, "_target"},   64'(br.pc_target),     64'(br.id_target));
    check({ph, "_cnt_br"},   64'(br.cnt_branches),  64'(m_branches));
    check({ph, "_cnt_tk"},   64'(br.cnt_taken),     64'(m_taken));
    check({ph, "_cnt_st"},   64'(br.cnt_stalls),    64'(m_stalls));
    check({ph, "_timeout"},  64'(br.stall_timeout), 64'(m_timeout));
  endtask

  task automatic model_update();
    if (rst_n !== 1'b1) begin
      m_branches = 0; m_taken = 0; m_stalls = 0; m_run = 0; m_timeout = 1'b0;
    end else begin
      if (br.cnt_clear) begin
        m_branches = 0; m_taken = 0; m_stalls = 0; m_timeout = 1'b0;
      end else begin
        if (m_stall && m_run >= MAX_STALL) m_timeout = 1'b1;
        if (m_resolve) m_branches = sat(m_branches);
        if (m_tk)      m_taken    = sat(m_taken);
        if (m_stall)   m_stalls   = sat(m_stalls);
      end
      m_run = m_stall ? ((m_run < MAX_STALL) ? m_run + 1 : m_run) : 0;
    end
  endtask

  // Inputs are driven at the falling edge; one call covers one full clock cycle.
  task automatic cycle(input string ph);
    #1;
    eval_and_check(ph);
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    br.id_valid = 1'b0; br.id_cond_type = 2'b00;
    br.id_rs = '0; br.id_rt = '0; br.id_rs_data = '0; br.id_rt_data = '0;
    br.id_target = 32'h0000_1000;
    br.ex_reg_write = 1'b0; br.ex_mem_read = 1'b0; br.ex_dst = '0;
    br.mem_reg_write = 1'b0; br.mem_mem_read = 1'b0; br.mem_dst = '0; br.mem_alu_result = '0;
    br.wb_reg_write = 1'b0; br.wb_dst = '0; br.wb_data = '0;
    br.cnt_clear = 1'b0;
  endtask

  task automatic clear_counters();
    idle_inputs();
    br.cnt_clear = 1'b1;
    cycle("clr");
    br.cnt_clear = 1'b0;
  endtask

  task automatic branch(input logic [1:0] ct, input int rs, input int rt,
                        input int rs_d, input int rt_d);
    br.id_valid = 1'b1; br.id_cond_type = ct;
    br.id_rs = RW'(rs); br.id_rt = RW'(rt);
    br.id_rs_data = DW'(rs_d); br.id_rt_data = DW'(rt_d);
  endtask

  int nst;

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    branch(BEQ, 3, 4, 0, 0);
    br.ex_reg_write = 1'b1; br.ex_dst = 5'd3;
    @(negedge clk); @(negedge clk);
    #1;
    check("reset_stall_forced", 64'(br.stall_if_id), 64'd0);
    check("reset_cnt_stalls",   64'(br.cnt_stalls), 64'd0);
    check("reset_timeout",      64'(br.stall_timeout), 64'd0);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    cycle("idle");

    // Branch with no hazard
    branch(BEQ, 3, 4, 32'h10, 32'h10);
    br.id_target = 32'h0000_2468;
    cycle("nohaz");
    check("nohaz_redirect_seen", 64'(obs_redirect), 64'd1);
    idle_inputs();
    cycle("nohaz_after");
    check("nohaz_cnt_br", 64'(br.cnt_branches), 64'd1);
    check("nohaz_cnt_tk", 64'(br.cnt_taken), 64'd1);

    // EX ALU hazard: one stall, then MEM forwarding
    clear_counters();
    branch(BNQ, 3, 4, 0, 5);
    br.ex_reg_write = 1'b1; br.ex_dst = 5'd3;
    cycle("exalu0");
    check("exalu_stall0", 64'(obs_stall), 64'd1);
    br.ex_reg_write = 1'b0; br.ex_dst = '0;
    br.mem_reg_write = 1'b1; br.mem_dst = 5'd3; br.mem_alu_result = 32'd5;
    cycle("exalu1");
    check("exalu_stall1", 64'(obs_stall), 64'd0);
    check("exalu_not_taken", 64'(obs_redirect), 64'd0);
    idle_inputs();
    cycle("exalu_after");
    check("exalu_cnt_st", 64'(br.cnt_stalls), 64'd1);
    check("exalu_cnt_tk", 64'(br.cnt_taken), 64'd0);

    // EX load hazard: two stalls, then WB forwarding
    clear_counters();
    nst = 0;
    branch(BEQ, 3, 4, 0, 7);
    br.ex_reg_write = 1'b1; br.ex_mem_read = 1'b1; br.ex_dst = 5'd3;
    cycle("exld0"); nst += int'(obs_stall);
    br.ex_reg_write = 1'b0; br.ex_mem_read = 1'b0; br.ex_dst = '0;
    br.mem_reg_write = 1'b1; br.mem_mem_read = 1'b1; br.mem_dst = 5'd3;
    cycle("exld1"); nst += int'(obs_stall);
    br.mem_reg_write = 1'b0; br.mem_mem_read = 1'b0; br.mem_dst = '0;
    br.wb_reg_write = 1'b1; br.wb_dst = 5'd3; br.wb_data = 32'd7;
    cycle("exld2"); nst += int'(obs_stall);
    check("exld_stall_count", 64'(nst), 64'd2);
    check("exld_wb_taken", 64'(obs_redirect), 64'd1);
    idle_inputs();
    cycle("exld_after");
    check("exld_timeout", 64'(br.stall_timeout), 64'd0);

    // Register 0 never matches
    branch(BEQ, 0, 5, 0, 0);
    br.ex_reg_write = 1'b1; br.ex_dst = '0;
    cycle("r0");
    check("r0_no_stall", 64'(obs_stall), 64'd0);
    check("r0_taken", 64'(obs_redirect), 64'd1);

    // Watchdog
    clear_counters();
    branch(BNQ, 6, 0, 0, 0);
    br.ex_reg_write = 1'b1; br.ex_dst = 5'd6;
    for (int i = 0; i < 5; i++) cycle("wd");
    check("wd_timeout_set", 64'(br.stall_timeout), 64'd1);
    check("wd_cnt_st", 64'(br.cnt_stalls), 64'd5);
    clear_counters();
    check("wd_clear_timeout", 64'(br.stall_timeout), 64'd0);
    check("wd_clear_cnt_st", 64'(br.cnt_stalls), 64'd0);

    // Saturation of the stall counter
    branch(BEQ, 7, 2, 0, 0);
    br.ex_reg_write = 1'b1; br.ex_dst = 5'd7;
    for (int i = 0; i < CNT_MAX + 4; i++) cycle("sat");
    check("sat_cnt_st", 64'(br.cnt_stalls), 64'hFFFF);

    // Reset asserted mid-stall
    #1;
    check("pre_rst_stall", 64'(br.stall_if_id), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_stall_zero", 64'(br.stall_if_id), 64'd0);
    check("rst_cnt_st_zero", 64'(br.cnt_stalls), 64'd0);
    check("rst_timeout_zero", 64'(br.stall_timeout), 64'd0);
    m_branches = 0; m_taken = 0; m_stalls = 0; m_run = 0; m_timeout = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle("post_rst");
    check("post_rst_stall", 64'(obs_stall), 64'd1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      br.id_valid       = ($urandom_range(0, 3) != 0);
      br.id_cond_type   = 2'($urandom_range(0, 3));
      br.id_rs          = RW'($urandom_range(0, 3));
      br.id_rt          = RW'($urandom_range(0, 3));
      br.id_rs_data     = DW'($urandom_range(0, 3));
      br.id_rt_data     = DW'($urandom_range(0, 3));
      br.id_target      = $urandom;
      br.ex_reg_write   = ($urandom_range(0, 2) == 0);
      br.ex_mem_read    = 1'($urandom_range(0, 1));
      br.ex_dst         = RW'($urandom_range(0, 3));
      br.mem_reg_write  = 1'($urandom_range(0, 1));
      br.mem_mem_read   = ($urandom_range(0, 2) == 0);
      br.mem_dst        = RW'($urandom_range(0, 3));
      br.mem_alu_result = DW'($urandom_range(0, 3));
      br.wb_reg_write   = 1'($urandom_range(0, 1));
      br.wb_dst         = RW'($urandom_range(0, 3));
      br.wb_data        = DW'($urandom_range(0, 3));
      br.cnt_clear      = ($urandom_range(0, 49) == 0);
      cycle("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
